mem_bus_arbiter: RTL and testbench

- Shares the single memory controller bus between two requesters: instruction fetch and the execute stage's load/store port.
- Sits between those requesters and the memory controller.
- Sequences each access over a fixed number of memory wait cycles and returns read data with a one-cycle ready pulse.
- Data accesses take priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: instruction fetch vs. load/store, data-first with fetch starvation guard.
// Optional alignment check enabled by defining MEM_BUS_ARBITER_ALIGN_CHECK_EN (adds data_misaligned output).
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_width,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_rdata,
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
    output logic              data_misaligned,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_width,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_FETCH, BUSY_DATA} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [STV_W-1:0]  starve_reg, starve_next;
    logic              misalign_reg, misalign_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [1:0]        mem_width_reg, mem_width_next;
    logic              mem_we_reg, mem_we_next;
    logic              mem_re_reg, mem_re_next;
    logic [DATA_W-1:0] fetch_rdata_reg, data_rdata_reg;

    logic last_cycle, arb_point, fetch_elig, data_elig;
    logic grant_data, grant_fetch, misaligned_req, data_capture;

`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
    assign misaligned_req = ((data_width == 2'd1) && data_addr[0]) ||
                            ((data_width == 2'd2) && (data_addr[1:0] != 2'b00));
    assign data_misaligned = data_ready && misalign_reg;
`else
    assign misaligned_req = 1'b0;
`endif

    // A misaligned access is never issued, so it finishes after its first busy cycle.
    assign last_cycle  = (state_reg != IDLE) && ((wait_cnt_reg == CNT_LAST) || misalign_reg);
    assign fetch_ready = (state_reg == BUSY_FETCH) && last_cycle;
    assign data_ready  = (state_reg == BUSY_DATA) && last_cycle;
    assign arb_point   = (state_reg == IDLE) || last_cycle;

    assign fetch_elig  = fetch_req && !fetch_ready;
    assign data_elig   = data_req && !data_ready;
    assign grant_data  = arb_point && data_elig && (!fetch_elig || (starve_reg != STV_MAX));
    assign grant_fetch = arb_point && fetch_elig && !grant_data;

    assign data_capture = data_ready && !misalign_reg;
    assign fetch_rdata  = fetch_ready ? mem_rdata : fetch_rdata_reg;
    assign data_rdata   = data_capture ? mem_rdata : data_rdata_reg;

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_width = mem_width_reg;
    assign mem_we    = mem_we_reg;
    assign mem_re    = mem_re_reg;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        starve_next    = starve_reg;
        misalign_next  = misalign_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_width_next = mem_width_reg;
        mem_we_next    = mem_we_reg;
        mem_re_next    = mem_re_reg;

        if (grant_data) begin
            state_next     = BUSY_DATA;
            wait_cnt_next  = '0;
            misalign_next  = misaligned_req;
            mem_addr_next  = data_addr;
            mem_wdata_next = data_wdata;
            mem_width_next = data_width;
            mem_we_next    = data_we && !misaligned_req;
            mem_re_next    = !data_we && !misaligned_req;
        end else if (grant_fetch) begin
            state_next     = BUSY_FETCH;
            wait_cnt_next  = '0;
            misalign_next  = 1'b0;
            mem_addr_next  = fetch_addr;
            mem_width_next = 2'd2;
            mem_we_next    = 1'b0;
            mem_re_next    = 1'b1;
        end else if (arb_point) begin
            // Nothing to grant: drop the strobes, leave address/data/width parked.
            state_next     = IDLE;
            wait_cnt_next  = '0;
            misalign_next  = 1'b0;
            mem_we_next    = 1'b0;
            mem_re_next    = 1'b0;
        end else begin
            wait_cnt_next  = wait_cnt_reg + 1'b1;
        end

        if (arb_point) begin
            if (grant_fetch || !fetch_req) begin
                starve_next = '0;
            end else if (grant_data && (starve_reg != STV_MAX)) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            starve_reg      <= '0;
            misalign_reg    <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            mem_width_reg   <= 2'd0;
            mem_we_reg      <= 1'b0;
            mem_re_reg      <= 1'b0;
            fetch_rdata_reg <= '0;
            data_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            starve_reg    <= starve_next;
            misalign_reg  <= misalign_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_width_reg <= mem_width_next;
            mem_we_reg    <= mem_we_next;
            mem_re_reg    <= mem_re_next;
            if (fetch_ready) begin
                fetch_rdata_reg <= mem_rdata;
            end
            if (data_capture) begin
                data_rdata_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle sequences and a randomized
// run checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int LAT    = 3;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready;
    logic [31:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [1:0]  data_width = 2'd0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
    logic        data_misaligned;
`endif

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_width(data_width),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ready(data_ready), .data_rdata(data_rdata),
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
        .data_misaligned(data_misaligned),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the access in flight is a record with a countdown of remaining cycles.
    int          m_kind;   // 0 none, 1 fetch, 2 data
    int          m_left;
    bit          m_mis;
    logic [31:0] m_addr, m_wdata, m_frd, m_drd;
    logic [1:0]  m_width;
    bit          m_we, m_re;
    int          m_starve;
    int          n_fetch_done = 0, n_data_done = 0;

    function automatic bit is_misaligned(input logic [1:0] w, input logic [31:0] a);
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
        return (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_kind = 0; m_left = 0; m_mis = 0; m_starve = 0;
                m_addr = '0; m_wdata = '0; m_width = '0; m_we = 0; m_re = 0;
                m_frd = '0; m_drd = '0;
            end else begin
                bit e_fr, e_dr, fe, de, mis;
                logic [31:0] e_frd, e_drd;
                e_fr  = (m_kind == 1) && (m_left == 1);
                e_dr  = (m_kind == 2) && (m_left == 1);
                e_frd = e_fr ? mem_rdata : m_frd;
                e_drd = (e_dr && !m_mis) ? mem_rdata : m_drd;
                check("model fetch_ready", fetch_ready, e_fr);
                check("model data_ready", data_ready, e_dr);
                check("model mem_re", mem_re, m_re);
                check("model mem_we", mem_we, m_we);
                check("model fetch_rdata", fetch_rdata, e_frd);
                check("model data_rdata", data_rdata, e_drd);
                if (m_re || m_we) begin
                    check("model mem_addr", mem_addr, m_addr);
                    check("model mem_width", mem_width, m_width);
                end
                if (m_we) check("model mem_wdata", mem_wdata, m_wdata);
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
                check("model data_misaligned", data_misaligned, e_dr && m_mis);
`endif
                if (e_fr) begin m_frd = mem_rdata; n_fetch_done++; end
                if (e_dr) begin n_data_done++; if (!m_mis) m_drd = mem_rdata; end
                if (m_kind == 0 || m_left == 1) begin
                    fe = fetch_req && !e_fr;
                    de = data_req && !e_dr;
                    if (de && (!fe || m_starve < STARVE)) begin
                        mis = is_misaligned(data_width, data_addr);
                        m_starve = fetch_req ? ((m_starve < STARVE) ? m_starve + 1 : m_starve) : 0;
                        m_kind = 2; m_left = mis ? 1 : LAT; m_mis = mis;
                        m_addr = data_addr; m_wdata = data_wdata; m_width = data_width;
                        m_we = data_we && !mis; m_re = !data_we && !mis;
                    end else if (fe) begin
                        m_starve = 0;
                        m_kind = 1; m_left = LAT; m_mis = 0;
                        m_addr = fetch_addr; m_width = 2'd2; m_we = 0; m_re = 1;
                    end else begin
                        if (!fetch_req) m_starve = 0;
                        m_kind = 0; m_left = 0; m_mis = 0; m_we = 0; m_re = 0;
                    end
                end else begin
                    m_left--;
                end
            end
        end
    end

    typedef struct {
        bit          is_data;
        bit          we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          exp_we;
        bit          exp_re;
        logic [1:0]  exp_width;
        bit          short_acc;
        bit          chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic do_vec(input vec_t v, input int idx);
        int lat;
        lat = v.short_acc ? 1 : LAT;
        @(posedge clk); #1;
        if (v.is_data) begin
            data_req = 1; data_we = v.we; data_width = v.width;
            data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            fetch_req = 1; fetch_addr = v.addr;
        end
        mem_rdata = v.rdata;
        @(negedge clk);
        check($sformatf("vec%0d ready before grant", idx), fetch_ready | data_ready, 0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d c%0d mem_re", idx, k), mem_re, v.exp_re);
            check($sformatf("vec%0d c%0d mem_we", idx, k), mem_we, v.exp_we);
            if (!v.short_acc) begin
                check($sformatf("vec%0d c%0d mem_addr", idx, k), mem_addr, v.addr);
                check($sformatf("vec%0d c%0d mem_width", idx, k), mem_width, v.exp_width);
                if (v.exp_we) check($sformatf("vec%0d c%0d mem_wdata", idx, k), mem_wdata, v.wdata);
            end
            check($sformatf("vec%0d c%0d ready", idx, k),
                  v.is_data ? data_ready : fetch_ready, k == lat);
            check($sformatf("vec%0d c%0d other ready", idx, k),
                  v.is_data ? fetch_ready : data_ready, 0);
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
            check($sformatf("vec%0d c%0d data_misaligned", idx, k), data_misaligned,
                  v.is_data && v.short_acc && k == lat);
`endif
            if (k == lat && v.chk_rd)
                check($sformatf("vec%0d rdata", idx), v.is_data ? data_rdata : fetch_rdata, v.exp_rdata);
        end
        @(posedge clk); #1;
        fetch_req = 0; data_req = 0; mem_rdata = 32'h0F0F_1234;
        @(negedge clk);
        check($sformatf("vec%0d idle strobes", idx), {30'd0, mem_re, mem_we}, 0);
        if (v.chk_rd)
            check($sformatf("vec%0d rdata hold", idx), v.is_data ? data_rdata : fetch_rdata, v.exp_rdata);
        if (!v.short_acc) check($sformatf("vec%0d mem_addr hold", idx), mem_addr, v.addr);
    endtask

    initial begin
        vecs[0] = '{0, 0, 2'd0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 2'd2, 0, 1, 32'hDEAD_BEEF};
        vecs[1] = '{1, 1, 2'd0, 32'h0000_0204, 32'h55, 32'h1234_5678, 1, 0, 2'd0, 0, 0, 32'h0};
        vecs[2] = '{1, 0, 2'd2, 32'h0000_0300, 32'h0, 32'hA5A5_0F0F, 0, 1, 2'd2, 0, 1, 32'hA5A5_0F0F};
        vecs[3] = '{1, 0, 2'd1, 32'h0000_0402, 32'h0, 32'h0000_BEEF, 0, 1, 2'd1, 0, 1, 32'h0000_BEEF};
        vecs[4] = '{0, 0, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h1357_9BDF, 0, 1, 2'd2, 0, 1, 32'h1357_9BDF};
`ifdef MEM_BUS_ARBITER_ALIGN_CHECK_EN
        vecs[5] = '{1, 0, 2'd2, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, 0, 2'd2, 1, 1, 32'h0000_BEEF};
`else
        vecs[5] = '{1, 0, 2'd2, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 0, 1, 2'd2, 0, 1, 32'hCAFE_F00D};
`endif

        // Reset values while rst_n is held low.
        #1;
        check("reset fetch_ready", fetch_ready, 0);
        check("reset data_ready", data_ready, 0);
        check("reset mem_we", mem_we, 0);
        check("reset mem_re", mem_re, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset mem_width", mem_width, 0);
        check("reset fetch_rdata", fetch_rdata, 0);
        check("reset data_rdata", data_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) do_vec(vecs[i], i);

        // Both requesters held high: data wins from idle, then the two alternate with no gap.
        begin
            int got, cyc, last_cyc;
            @(posedge clk); #1;
            fetch_req = 1; fetch_addr = 32'h0000_0800;
            data_req = 1; data_we = 0; data_width = 2'd2; data_addr = 32'h0000_0900;
            mem_rdata = 32'h2468_ACE0;
            got = 0; cyc = 0; last_cyc = 0;
            while (got < 8 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (fetch_ready || data_ready) begin
                    check("b2b single ready", fetch_ready & data_ready, 0);
                    check($sformatf("b2b order%0d data", got), data_ready, (got % 2) == 0);
                    if (got > 0) check($sformatf("b2b gap%0d", got), cyc - last_cyc, LAT);
                    last_cyc = cyc;
                    got++;
                end
            end
            check("b2b completions", got, 8);
            @(posedge clk); #1;
            fetch_req = 0; data_req = 0;
            repeat (LAT + 2) @(negedge clk);
        end

        // Asynchronous reset in the middle of a data access.
        @(posedge clk); #1;
        data_req = 1; data_we = 0; data_width = 2'd2; data_addr = 32'h0000_0500;
        mem_rdata = 32'h7777_1111;
        repeat (3) @(negedge clk);
        #2 rst_n = 0; data_req = 0;
        #1;
        check("mid reset fetch_ready", fetch_ready, 0);
        check("mid reset data_ready", data_ready, 0);
        check("mid reset mem_re", mem_re, 0);
        check("mid reset mem_we", mem_we, 0);
        check("mid reset mem_addr", mem_addr, 0);
        check("mid reset mem_wdata", mem_wdata, 0);
        check("mid reset mem_width", mem_width, 0);
        check("mid reset fetch_rdata", fetch_rdata, 0);
        check("mid reset data_rdata", data_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            check($sformatf("post reset no ready c%0d", k), data_ready | fetch_ready, 0);
        end

        // Randomized traffic; requests held until their ready, then renewed or dropped.
        n_fetch_done = 0; n_data_done = 0;
        for (int c = 0; c < 3000; c++) begin
            bit fr, dr;
            @(negedge clk);
            fr = fetch_ready; dr = data_ready;
            @(posedge clk); #1;
            mem_rdata = $urandom;
            if (!fetch_req || fr) begin
                fetch_req = ($urandom_range(0, 2) != 0);
                fetch_addr = $urandom;
            end
            if (!data_req || dr) begin
                data_req = ($urandom_range(0, 2) != 0);
                data_we = $urandom_range(0, 1);
                data_width = 2'($urandom_range(0, 2));
                data_addr = $urandom;
                data_wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        fetch_req = 0; data_req = 0;
        repeat (LAT + 2) @(negedge clk);
        check("random fetch completions seen", n_fetch_done > 10, 1);
        check("random data completions seen", n_data_done > 10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
